// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : hazard_scoreboard_if
// Brief    : ID-stage issue/operand bundle and hazard-scoreboard result signals.
// Revision : 1.0
//------------------------------------------------------------------------------

`ifndef HAZARDSELEMP
`define HAZARDSELEMP 1'b1
`endif
`ifndef HAZARDSELNORMAL
`define HAZARDSELNORMAL 1'b0
`endif

interface hazard_scoreboard_if #(
    parameter int REGADDRWIDTH  = 5,
    parameter int LATWIDTH      = 3,
    parameter int STALLCNTWIDTH = 16
);
    localparam int c_NUMREGS = 2 ** REGADDRWIDTH;

    logic                      issue_valid;
    logic                      issue_rf_write;
    logic [REGADDRWIDTH-1:0]   issue_rd_addr;
    logic [LATWIDTH-1:0]       issue_lat;
    logic [REGADDRWIDTH-1:0]   rs1_addr;
    logic [REGADDRWIDTH-1:0]   rs2_addr;
    logic                      rs1_used;
    logic                      rs2_used;
    logic                      branch_id;
    logic                      flush;
    logic                      freeze;
    logic                      hazard_nop_sel;
    logic [c_NUMREGS-1:0]      busy_mask;
    logic [STALLCNTWIDTH-1:0]  stall_cnt;

    // master: the ID stage; slave: the scoreboard
    modport master (
        output issue_valid, issue_rf_write, issue_rd_addr, issue_lat,
               rs1_addr, rs2_addr, rs1_used, rs2_used, branch_id, flush, freeze,
        input  hazard_nop_sel, busy_mask, stall_cnt
    );
    modport slave (
        input  issue_valid, issue_rf_write, issue_rd_addr, issue_lat,
               rs1_addr, rs2_addr, rs1_used, rs2_used, branch_id, flush, freeze,
        output hazard_nop_sel, busy_mask, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard driving the ID/EX bubble select.
// Revision : 1.0
//------------------------------------------------------------------------------

module hazard_scoreboard #(
    parameter int REGADDRWIDTH  = 5,
    parameter int LATWIDTH      = 3,
    parameter int FWD_SLACK     = 1,
    parameter int STALLCNTWIDTH = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    hazard_scoreboard_if.slave   sb
);
    localparam int c_NUMREGS = 2 ** REGADDRWIDTH;

    logic [c_NUMREGS-1:0][LATWIDTH-1:0] r_cnt;
    logic [c_NUMREGS-1:0][LATWIDTH-1:0] w_cnt_nxt;
    logic [STALLCNTWIDTH-1:0]           r_stall_cnt;

    logic [LATWIDTH-1:0] w_thr;
    logic                w_hz1;
    logic                w_hz2;
    logic                w_stall;
    logic                w_accept;

    // Branches resolve in ID, so they cannot use the forwarding slack
    assign w_thr = sb.branch_id ? '0 : LATWIDTH'(FWD_SLACK);

    assign w_hz1 = sb.rs1_used && (sb.rs1_addr != '0) && (r_cnt[sb.rs1_addr] > w_thr);
    assign w_hz2 = sb.rs2_used && (sb.rs2_addr != '0) && (r_cnt[sb.rs2_addr] > w_thr);

    assign w_stall  = sb.issue_valid && !sb.flush && (w_hz1 || w_hz2);
    assign w_accept = sb.issue_valid && !sb.flush && !w_stall && !sb.freeze &&
                      sb.issue_rf_write && (sb.issue_rd_addr != '0) &&
                      (sb.issue_lat != '0);

    // Decrement everything, then keep the later of the old and new write-back
    // so a short write cannot overtake an older long write to the same rd.
    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 1; r < c_NUMREGS; r++) begin
            w_cnt_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - LATWIDTH'(1) : '0;
        end
        if (w_accept && (sb.issue_lat > w_cnt_nxt[sb.issue_rd_addr])) begin
            w_cnt_nxt[sb.issue_rd_addr] = sb.issue_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else if (!sb.freeze) begin
            r_cnt <= w_cnt_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALLCNTWIDTH'(1);
            end
        end
    end

    always_comb begin
        sb.busy_mask = '0;
        for (int r = 0; r < c_NUMREGS; r++) begin
            sb.busy_mask[r] = (r_cnt[r] != '0);
        end
    end

    assign sb.hazard_nop_sel = w_stall ? `HAZARDSELEMP : `HAZARDSELNORMAL;
    assign sb.stall_cnt      = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_hazard_scoreboard
// Brief    : Vector-table and queue-scoreboard bench for hazard_scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------

module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    logic rst4;

    hazard_scoreboard_if #(.REGADDRWIDTH(5), .LATWIDTH(3), .STALLCNTWIDTH(16)) bus ();
    hazard_scoreboard_if #(.REGADDRWIDTH(5), .LATWIDTH(3), .STALLCNTWIDTH(4))  bus4 ();

    hazard_scoreboard #(.REGADDRWIDTH(5), .LATWIDTH(3), .FWD_SLACK(1), .STALLCNTWIDTH(16))
        dut (.clk(clk), .rst(rst), .sb(bus.slave));
    hazard_scoreboard #(.REGADDRWIDTH(5), .LATWIDTH(3), .FWD_SLACK(1), .STALLCNTWIDTH(4))
        dut4 (.clk(clk), .rst(rst4), .sb(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic        wr;
        logic [4:0]  rd;
        logic [2:0]  lat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        br;
        logic        fl;
        logic        fz;
        logic        nop;
        logic [31:0] busy;
        int          sc;
    } vec_t;

    typedef struct {
        string       name;
        logic        nop;
        logic [31:0] busy;
        int          sc;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] b(input int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic v, input logic w,
                                input int rd, input int lat, input int rs1, input int rs2,
                                input logic u1, input logic u2, input logic br, input logic fl,
                                input logic fz, input logic nop, input logic [31:0] busy,
                                input int sc);
        vec_t t;
        t.name = n; t.rst = r; t.valid = v; t.wr = w;
        t.rd = 5'(rd); t.lat = 3'(lat); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.u1 = u1; t.u2 = u2; t.br = br; t.fl = fl; t.fz = fz;
        t.nop = nop; t.busy = busy; t.sc = sc;
        return t;
    endfunction

    function automatic vec_t idle(input string n, input logic [31:0] busy, input int sc);
        return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, sc);
    endfunction

    function automatic vec_t iss(input string n, input int rd, input int lat,
                                 input logic [31:0] busy, input int sc);
        return mk(n, 0, 1, 1, rd, lat, 0, 0, 0, 0, 0, 0, 0, 0, busy, sc);
    endfunction

    function automatic vec_t rdr(input string n, input int rs1, input logic br, input logic nop,
                                 input logic [31:0] busy, input int sc);
        return mk(n, 0, 1, 0, 0, 0, rs1, 0, 1, 0, br, 0, 0, nop, busy, sc);
    endfunction

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        rst                = t.rst;
        bus.issue_valid    = t.valid;
        bus.issue_rf_write = t.wr;
        bus.issue_rd_addr  = t.rd;
        bus.issue_lat      = t.lat;
        bus.rs1_addr       = t.rs1;
        bus.rs2_addr       = t.rs2;
        bus.rs1_used       = t.u1;
        bus.rs2_used       = t.u2;
        bus.branch_id      = t.br;
        bus.flush          = t.fl;
        bus.freeze         = t.fz;
    endtask

    task automatic drive4(input logic v, input logic w, input int rd, input int lat,
                          input int rs1, input logic br);
        bus4.issue_valid    = v;
        bus4.issue_rf_write = w;
        bus4.issue_rd_addr  = 5'(rd);
        bus4.issue_lat      = 3'(lat);
        bus4.rs1_addr       = 5'(rs1);
        bus4.rs2_addr       = '0;
        bus4.rs1_used       = (rs1 != 0);
        bus4.rs2_used       = 1'b0;
        bus4.branch_id      = br;
        bus4.flush          = 1'b0;
        bus4.freeze         = 1'b0;
    endtask

    task automatic check_pop(input bit sat);
        exp_t e;
        if (sbq.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        if (sat) begin
            cmp({e.name, "_nop"},   32'(bus4.hazard_nop_sel), 32'(e.nop));
            cmp({e.name, "_busy"},  bus4.busy_mask,           e.busy);
            cmp({e.name, "_stall"}, 32'(bus4.stall_cnt),      32'(e.sc));
        end else begin
            cmp({e.name, "_nop"},   32'(bus.hazard_nop_sel),  32'(e.nop));
            cmp({e.name, "_busy"},  bus.busy_mask,            e.busy);
            cmp({e.name, "_stall"}, 32'(bus.stall_cnt),       32'(e.sc));
        end
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        rst4 = 1'b1;
        apply(idle("init", 0, 0));
        rst = 1'b1;
        drive4(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        tbl.push_back(idle("reset_state", 0, 0));
        tbl.push_back(iss ("rst_arm",   5, 3, 0, 0));
        tbl.push_back(mk  ("rst_mid",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, b(5), 0));
        tbl.push_back(idle("rst_after", 0, 0));
        tbl.push_back(iss ("lu_load",   5, 2, 0, 0));
        tbl.push_back(mk  ("lu_stall",  0, 1, 1, 6, 1, 5, 0, 1, 0, 0, 0, 0, 1, b(5), 0));
        tbl.push_back(mk  ("lu_go",     0, 1, 1, 6, 1, 5, 0, 1, 0, 0, 0, 0, 0, b(5), 1));
        tbl.push_back(idle("lu_after",  b(6), 1));
        tbl.push_back(iss ("ba_alu",    7, 1, 0, 1));
        tbl.push_back(mk  ("ba_stall",  0, 1, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 1, b(7), 1));
        tbl.push_back(mk  ("ba_go",     0, 1, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(iss ("bl_load",   7, 2, 0, 2));
        tbl.push_back(mk  ("bl_indep",  0, 1, 1, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, b(7), 2));
        tbl.push_back(mk  ("bl_stall",  0, 1, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 1, b(7) | b(8), 2));
        tbl.push_back(mk  ("bl_go",     0, 1, 0, 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 3));
        tbl.push_back(iss ("nb_alu",    7, 1, 0, 3));
        tbl.push_back(mk  ("nb_fwd",    0, 1, 1, 10, 1, 7, 0, 1, 0, 0, 0, 0, 0, b(7), 3));
        tbl.push_back(idle("nb_after",  b(10), 3));
        tbl.push_back(iss ("waw_long",  9, 6, 0, 3));
        tbl.push_back(iss ("waw_short", 9, 1, b(9), 3));
        tbl.push_back(rdr ("waw_rd5",   9, 0, 1, b(9), 3));
        tbl.push_back(rdr ("waw_rd4",   9, 0, 1, b(9), 4));
        tbl.push_back(rdr ("waw_rd3",   9, 0, 1, b(9), 5));
        tbl.push_back(rdr ("waw_rd2",   9, 0, 1, b(9), 6));
        tbl.push_back(rdr ("waw_rd1",   9, 0, 0, b(9), 7));
        tbl.push_back(iss ("fz_load",   3, 2, 0, 7));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("fz_hold%0d", i), 0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1, 1, b(3), 7));
        tbl.push_back(rdr ("fz_cnt2",   3, 0, 1, b(3), 7));
        tbl.push_back(rdr ("fz_cnt1",   3, 0, 0, b(3), 8));
        tbl.push_back(iss ("fl_load",   4, 2, 0, 8));
        tbl.push_back(mk  ("fl_flush",  0, 1, 1, 11, 3, 4, 0, 1, 0, 0, 1, 0, 0, b(4), 8));
        tbl.push_back(idle("fl_norec",  b(4), 8));
        tbl.push_back(idle("fl_clear",  0, 8));
        tbl.push_back(iss ("x0_write",  0, 7, 0, 8));
        tbl.push_back(mk  ("x0_read",   0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 8));
        tbl.push_back(iss ("nu_load",   12, 3, 0, 8));
        tbl.push_back(mk  ("nu_unused", 0, 1, 0, 0, 0, 12, 12, 0, 0, 1, 0, 0, 0, b(12), 8));
        tbl.push_back(mk  ("self_dep",  0, 1, 1, 13, 3, 13, 0, 1, 0, 0, 0, 0, 0, b(12), 8));
        tbl.push_back(idle("self_rec",  b(12) | b(13), 8));
        tbl.push_back(idle("sim_cnt1",  b(13), 8));
        tbl.push_back(iss ("sim_issue", 13, 2, b(13), 8));
        tbl.push_back(rdr ("sim_stall", 13, 0, 1, b(13), 8));
        tbl.push_back(idle("sim_tail",  b(13), 9));
        tbl.push_back(idle("sim_done",  0, 9));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            sbq.push_back('{tbl[i].name, tbl[i].nop, tbl[i].busy, tbl[i].sc});
            @(negedge clk);
            check_pop(1'b0);
        end

        // Saturation on the 4-bit counter build: three rounds of 7 stalls
        @(posedge clk); #1;
        rst4 = 1'b0;
        drive4(0, 0, 0, 0, 0, 0);
        sbq.push_back('{"sat_reset", 1'b0, 32'd0, 0});
        @(negedge clk);
        check_pop(1'b1);
        n = 0;
        for (int rep = 0; rep < 3; rep++) begin
            @(posedge clk); #1;
            drive4(1, 1, 2, 7, 0, 0);
            sbq.push_back('{$sformatf("sat_issue%0d", rep), 1'b0, 32'd0, (n > 15) ? 15 : n});
            @(negedge clk);
            check_pop(1'b1);
            for (int k = 0; k < 7; k++) begin
                @(posedge clk); #1;
                drive4(1, 0, 0, 0, 2, 1);
                sbq.push_back('{$sformatf("sat_r%0d_k%0d", rep, k), 1'b1, b(2), (n > 15) ? 15 : n});
                @(negedge clk);
                check_pop(1'b1);
                n++;
            end
        end
        @(posedge clk); #1;
        drive4(0, 0, 0, 0, 0, 0);
        sbq.push_back('{"sat_final", 1'b0, 32'd0, 15});
        @(negedge clk);
        check_pop(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage load-use/branch hazard detector.
- Holds a per-register countdown scoreboard, so producers with any issue latency (ALU, load, multi-cycle MUL/DIV) are tracked instead of only EX/MEM neighbours.
- Sits beside the ID stage and drives hazard_nop_sel into the ID/EX bubble mux. Also exports a busy mask and a stall-cycle performance counter.

Parameters:
- REGADDRWIDTH, 5, register address width; NUMREGS = 2**REGADDRWIDTH entries.
- LATWIDTH, 3, width of the latency field; maximum tracked latency is 2**LATWIDTH-1.
- FWD_SLACK, 1, largest countdown at which a non-branch consumer may proceed via forwarding.
- STALLCNTWIDTH, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  instruction in ID is valid
- issue_rf_write  in  1  ID instruction writes the register file
- issue_rd_addr  in  REGADDRWIDTH  destination of ID instruction
- issue_lat  in  LATWIDTH  cycles until the ID instruction's result is forwardable (ALU=1, load=2, MUL/DIV=n)
- rs1_addr  in  REGADDRWIDTH  source 1 of ID instruction
- rs2_addr  in  REGADDRWIDTH  source 2 of ID instruction
- rs1_used  in  1  source 1 is read
- rs2_used  in  1  source 2 is read
- branch_id  in  1  ID instruction resolves in ID (branch/jalr), so it needs operands with countdown 0
- flush  in  1  ID instruction is being squashed this cycle
- freeze  in  1  global pipeline freeze (memory wait)
- hazard_nop_sel  out  1  `HAZARDSELEMP when stalling, `HAZARDSELNORMAL otherwise
- busy_mask  out  NUMREGS  bit r = cnt[r] != 0
- stall_cnt  out  STALLCNTWIDTH  saturating count of stall cycles

Behaviour:
- State: cnt[r], a LATWIDTH-bit register for each r in 0..NUMREGS-1. cnt[0] is hard-wired to 0.
- Reset (rst=1 at a clk edge): all cnt = 0, stall_cnt = 0. This gives hazard_nop_sel = NORMAL and busy_mask = 0 combinationally after reset. Reset mid-countdown discards all pending entries.
- Threshold: thr = 0 if branch_id, else FWD_SLACK.
- Source hazard: hz_k = rs_k_used && rs_k_addr != 0 && cnt[rs_k_addr] > thr, for k = 1, 2.
- stall = issue_valid && !flush && (hz_1 || hz_2). This is combinational from current state and inputs, with no added latency.
- hazard_nop_sel = stall ? `HAZARDSELEMP : `HAZARDSELNORMAL. The output is forced to NORMAL when flush=1.
- accept = issue_valid && !flush && !stall && !freeze && issue_rf_write && issue_rd_addr != 0 && issue_lat != 0.
- Per-cycle update when freeze=0:
  - every nonzero cnt[r] decrements by 1;
  - then, if accept, cnt[issue_rd_addr] <= max(issue_lat, cnt_old[issue_rd_addr]-1), where cnt_old is the pre-decrement value.
  - The max protects WAW ordering when a short-latency write follows a long-latency write to the same register.
- When freeze=1: all cnt hold, nothing is accepted, stall_cnt holds. hazard_nop_sel is still driven combinationally.
- Timing: an instruction accepted at edge t with latency L has cnt = L during cycle t+1.
  - Load (L=2) followed by a dependent ALU op: exactly 1 bubble.
  - ALU (L=1) followed by a dependent branch: 1 bubble.
  - Load followed by an independent op, then a dependent branch: 1 bubble.
- A stalled instruction is not recorded. It is re-evaluated every cycle until it proceeds.
- stall_cnt increments by 1 on each non-frozen cycle with stall=1 and saturates at all-ones (no wrap).
- Sources with address 0, or with rs_used=0, never cause a stall. Writes to x0 are never tracked.
- An instruction whose rs equals its own rd checks the old cnt only. Self-dependency does not cause a stall.
- Simultaneous issue to register r while cnt[r]=1: the new value is max(L, 0) = L.

Test Plan:
- Reset: drive rst=1 while cnt[5]=3 is pending -> next cycle busy_mask=0, stall_cnt=0, hazard_nop_sel=NORMAL.
- Load-use: accept rd=5, lat=2; next cycle rs1=5 ALU op -> HAZARDSELEMP for 1 cycle, then NORMAL. stall_cnt=1.
- Branch after ALU and after load:
  - rd=7, lat=1, then branch_id reading rs2=7 -> 1 stall.
  - rd=7, lat=2, an independent op, then the branch -> 1 stall.
  - Non-branch consumer with lat=1 -> 0 stalls.
- Multi-cycle and WAW:
  - accept rd=9, lat=6, then next cycle rd=9, lat=1 -> cnt[9]=5, not 1.
  - A reader of x9 stalls until cnt[9] <= 1, which is 4 stall cycles.
- Freeze and flush:
  - freeze=1 for 3 cycles with cnt[3]=2 -> cnt holds at 2, stall_cnt unchanged.
  - flush=1 on a dependent ID op -> hazard_nop_sel=NORMAL and no entry recorded.
- x0 and saturation:
  - rd=0, lat=7 followed by rs1=0 reader -> no stall, busy_mask bit 0 stays 0.
  - Preload stall_cnt near all-ones (STALLCNTWIDTH=4 build) and stall for 20 cycles -> stall_cnt holds at 15.
